// File: rtl/fma_fetch_issue.sv
// Fetch/issue sequencer: walks a 16-entry program, issues FMA operand triples, handles NOP/JUMP/HALT locally.
// Latency: FMA word at PC_addr in cycle N appears on out_valid/out_a/b/c in cycle N+1; one issue per cycle sustained.
// Backpressure: while out_valid & !out_ready the PC, issue register and state all hold (fetch stalls).
// Optional feature macro FETCH_BOUND_EN: a NOP/FMA at PC=15 ends the run in DONE instead of wrapping to 0.
module fma_fetch_issue #(
    parameter int         CNT_W    = 8,
    parameter logic [3:0] START_PC = 4'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       PC_addr,
    input  logic [49:0]      instr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_a,
    output logic [15:0]      out_b,
    output logic [15:0]      out_c,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_FMA  = 2'b01;
    localparam logic [1:0] OP_JUMP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] pc;
    logic [3:0] pc_nxt;
    logic       load_fma;
    logic       load_ok;
    logic       handshake;
    logic [1:0] opcode;

    assign opcode    = instr_data[49:48];
    // The issue register can accept a new op when empty or being drained this cycle.
    assign load_ok   = !out_valid || out_ready;
    assign handshake = out_valid && out_ready;

    assign PC_addr = pc;
    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);

    // Next-state, next-PC and FMA-load decode from the current instruction word.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load_fma  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = START_PC;
                end
            end
            S_RUN: begin
                if (load_ok) begin
                    case (opcode)
                        OP_NOP, OP_FMA: begin
                            load_fma = (opcode == OP_FMA);
`ifdef FETCH_BOUND_EN
                            // Last slot: the op still executes, then the run ends with PC parked at 15.
                            if (pc == 4'hF) begin
                                state_nxt = S_DONE;
                            end else begin
                                pc_nxt = pc + 4'd1;
                            end
`else
                            pc_nxt = pc + 4'd1;
`endif
                        end
                        OP_JUMP: pc_nxt = instr_data[3:0];
                        default: state_nxt = S_DONE;  // HALT: PC holds
                    endcase
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pc_nxt    = START_PC;
            end
        endcase
    end

    // State and program counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= START_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Issue register: load on FMA, drop valid on a handshake with no replacement, otherwise hold operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= 16'h0000;
            out_b     <= 16'h0000;
            out_c     <= 16'h0000;
        end else if (load_fma) begin
            out_valid <= 1'b1;
            out_a     <= instr_data[47:32];
            out_b     <= instr_data[31:16];
            out_c     <= instr_data[15:0];
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of ops accepted downstream; survives DONE -> RUN restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
        end else if (handshake && (issue_cnt != {CNT_W{1'b1}})) begin
            issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fma_fetch_issue.sv
// Directed bench for fma_fetch_issue: combinational program memory model, hand-computed expectations.
// Latency checked cycle by cycle; sampling happens 1 time unit after each rising edge.
// Backpressure checked via out_ready stalls; bounded loops so the run always terminates.
module tb_fma_fetch_issue;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  PC_addr;
    logic [49:0] instr_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_c;
    logic        busy;
    logic        done;
    logic [7:0]  issue_cnt;

    logic [49:0] mem [16];

    int n_chk;
    int n_fail;

    fma_fetch_issue #(.CNT_W(8), .START_PC(4'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .PC_addr    (PC_addr),
        .instr_data (instr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .busy       (busy),
        .done       (done),
        .issue_cnt  (issue_cnt)
    );

    assign instr_data = mem[PC_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [49:0] i_fma(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        return {2'b01, a, b, c};
    endfunction

    function automatic logic [49:0] i_jump(input logic [3:0] t);
        return {2'b10, 44'h0, t};
    endfunction

    localparam logic [49:0] I_NOP  = 50'h0;
    localparam logic [49:0] I_HALT = {2'b11, 48'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 16; i++) mem[i] = I_HALT;
        mem[0] = i_fma(16'h3F80, 16'h4000, 16'h0000);
        mem[1] = i_fma(16'h4040, 16'h3F80, 16'h3F80);
        mem[2] = I_HALT;
    endtask

    int          n_pc;
    logic [3:0]  pc_seq [12];
    int          n_iss;
    logic [15:0] cap_a, cap_b, cap_c;

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        load_basic();
        step();
        step();

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_cnt",   32'(issue_cnt), 32'd0);
        chk("rst_pc",    32'(PC_addr),   32'd0);
        chk("rst_a",     32'(out_a),     32'd0);

        // Two FMAs then HALT, no backpressure
        rst = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_pc0",  32'(PC_addr), 32'd0);
        chk("t1_v0",   32'(out_valid), 32'd0);
        step();
        chk("t1_v1", 32'(out_valid), 32'd1);
        chk("t1_a1", 32'(out_a), 32'h3F80);
        chk("t1_b1", 32'(out_b), 32'h4000);
        chk("t1_c1", 32'(out_c), 32'h0000);
        chk("t1_pc1", 32'(PC_addr), 32'd1);
        step();
        chk("t1_v2", 32'(out_valid), 32'd1);
        chk("t1_a2", 32'(out_a), 32'h4040);
        chk("t1_b2", 32'(out_b), 32'h3F80);
        chk("t1_c2", 32'(out_c), 32'h3F80);
        chk("t1_cnt2", 32'(issue_cnt), 32'd1);
        step();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_v_end", 32'(out_valid), 32'd0);
        chk("t1_cnt", 32'(issue_cnt), 32'd2);
        chk("t1_pc_end", 32'(PC_addr), 32'd2);

        // Restart from DONE with a 3-cycle stall; count continues from 2
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_pc0", 32'(PC_addr), 32'd0);
        step();
        chk("t2_v1", 32'(out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            start = (k == 1);  // start in RUN must be ignored
            step();
            chk("t2_hold_a", 32'(out_a), 32'h3F80);
            chk("t2_hold_pc", 32'(PC_addr), 32'd1);
            chk("t2_hold_v", 32'(out_valid), 32'd1);
        end
        start = 1'b0;
        chk("t2_cnt_stall", 32'(issue_cnt), 32'd2);
        out_ready = 1'b1;
        step();
        chk("t2_a2", 32'(out_a), 32'h4040);
        chk("t2_pc2", 32'(PC_addr), 32'd2);
        chk("t2_cnt3", 32'(issue_cnt), 32'd3);
        step();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_cnt", 32'(issue_cnt), 32'd4);

        // NOP, JUMP 5, FMA, HALT; every other slot is a decoy FMA
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = i_fma(16'hDEAD, 16'hBEEF, 16'h0BAD);
        mem[0] = I_NOP;
        mem[1] = i_jump(4'd5);
        mem[5] = i_fma(16'h4100, 16'h4100, 16'h0000);
        mem[6] = I_HALT;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n_pc = 0;
        n_iss = 0;
        cap_a = '0; cap_b = '0; cap_c = '0;
        for (int k = 0; k < 12; k++) begin
            if (!busy) break;
            pc_seq[n_pc] = PC_addr;
            n_pc++;
            if (out_valid && out_ready) begin
                n_iss++;
                cap_a = out_a; cap_b = out_b; cap_c = out_c;
            end
            step();
        end
        chk("t3_term", 32'(busy), 32'd0);
        chk("t3_npc", 32'(n_pc), 32'd4);
        chk("t3_pc0", 32'(pc_seq[0]), 32'd0);
        chk("t3_pc1", 32'(pc_seq[1]), 32'd1);
        chk("t3_pc2", 32'(pc_seq[2]), 32'd5);
        chk("t3_pc3", 32'(pc_seq[3]), 32'd6);
        chk("t3_niss", 32'(n_iss), 32'd1);
        chk("t3_a", 32'(cap_a), 32'h4100);
        chk("t3_b", 32'(cap_b), 32'h4100);
        chk("t3_c", 32'(cap_c), 32'h0000);
        chk("t3_cnt", 32'(issue_cnt), 32'd1);
        chk("t3_done", 32'(done), 32'd1);

        // Asynchronous reset while an op is stalled at the output
        load_basic();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t4_pre_v", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_v", 32'(out_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_cnt", 32'(issue_cnt), 32'd0);
        chk("t4_pc", 32'(PC_addr), 32'd0);
        chk("t4_a", 32'(out_a), 32'd0);
        start = 1'b1;
        step();
        chk("t4_start_held", 32'(busy), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        step();
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_done", 32'(done), 32'd0);

        // Sixteen FMAs, no HALT
        for (int i = 0; i < 16; i++) mem[i] = i_fma(16'h1000 + 16'(i), 16'h2000, 16'h3000);
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef FETCH_BOUND_EN
        n_iss = 0;
        cap_a = '0;
        for (int k = 0; k < 40; k++) begin
            if (done && !out_valid) break;
            if (out_valid && out_ready) begin
                n_iss++;
                cap_a = out_a;
            end
            step();
        end
        chk("t5b_niss", 32'(n_iss), 32'd16);
        chk("t5b_done", 32'(done), 32'd1);
        chk("t5b_pc", 32'(PC_addr), 32'd15);
        chk("t5b_cnt", 32'(issue_cnt), 32'd16);
        chk("t5b_last_a", 32'(cap_a), 32'h100F);
`else
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 15) chk("t5w_pc15", 32'(PC_addr), 32'd15);
            if (k == 16) begin
                chk("t5w_wrap_pc", 32'(PC_addr), 32'd0);
                chk("t5w_wrap_busy", 32'(busy), 32'd1);
                chk("t5w_cnt16", 32'(issue_cnt), 32'd15);
            end
            if (k == 17) chk("t5w_wrap_a", 32'(out_a), 32'h1000);
            if (k == 255) chk("t5w_cnt254", 32'(issue_cnt), 32'd254);
            if (k == 256) chk("t5w_cnt255", 32'(issue_cnt), 32'd255);
        end
        chk("t5w_sat", 32'(issue_cnt), 32'd255);
        chk("t5w_busy_end", 32'(busy), 32'd1);
        chk("t5w_done_end", 32'(done), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
